// File: rtl/acc_readout.sv
// acc_readout: drains DEPTH signed accumulator entries in address order and requantizes
// each one: rounding arithmetic right shift, then saturation to OUT_WIDTH. Results leave
// through a 2-entry output FIFO with a valid/ready handshake.
// Optional feature: define ACC_READOUT_RELU_EN to clamp negative results to zero.
// DEPTH must be at least 2.
module acc_readout #(
  parameter int unsigned PARTIAL_SUM_WIDTH = 45,
  parameter int unsigned OUT_WIDTH         = 8,
  parameter int unsigned DEPTH             = 8,
  localparam int unsigned ADDR_W           = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                Start,
  input  logic [5:0]                          Shift,
  output logic                                Busy,
  output logic                                Done,
  output logic                                Acc_Rd_en,
  output logic [ADDR_W-1:0]                   Acc_Rd_Addr,
  input  logic signed [PARTIAL_SUM_WIDTH-1:0] Acc_Rd_Data,
  output logic signed [OUT_WIDTH-1:0]         Out_Data,
  output logic [ADDR_W-1:0]                   Out_Index,
  output logic                                Out_Valid,
  input  logic                                Out_Ready
);

  localparam int unsigned PW = PARTIAL_SUM_WIDTH;
  localparam int unsigned EW = PW + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic signed [EW-1:0] SatMax =
    {{(EW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [EW-1:0] SatMin =
    {{(EW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [5:0]                  shift_q, shift_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [ADDR_W-1:0]           rd_idx_q, rd_idx_d;
  logic                        inflight_q, inflight_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic signed [OUT_WIDTH-1:0] fifo_data_q [2];
  logic signed [OUT_WIDTH-1:0] fifo_data_d [2];
  logic [ADDR_W-1:0]           fifo_idx_q [2];
  logic [ADDR_W-1:0]           fifo_idx_d [2];
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0]                  count_q, count_d;

  logic                        pop, push, rd_en;
  logic [2:0]                  occ;
  logic signed [EW-1:0]        ext, rnd, shifted;
  logic signed [OUT_WIDTH-1:0] elem;

  // Requantize the returning read data: round, shift, saturate, optional ReLU
  always_comb begin
    ext = {Acc_Rd_Data[PW-1], Acc_Rd_Data};
    rnd = (shift_q != 6'd0) ? (EW'(1) << (shift_q - 6'd1)) : '0;
    if (32'(shift_q) >= PW) begin
      shifted = ext[EW-1] ? '1 : '0;
    end else begin
      shifted = (ext + rnd) >>> shift_q;
    end
    if (shifted > SatMax) begin
      elem = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end else if (shifted < SatMin) begin
      elem = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end else begin
      elem = shifted[OUT_WIDTH-1:0];
    end
`ifdef ACC_READOUT_RELU_EN
    if (elem[OUT_WIDTH-1]) begin
      elem = '0;
    end
`endif
  end

  // Next-state logic: pass FSM, read issue with FIFO credit, FIFO push/pop
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rd_idx_d   = rd_idx_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;

    pop  = (count_q != 2'd0) && Out_Ready;
    push = inflight_q;
    // Slots still claimed once this cycle's pop leaves; a new read needs one free slot.
    occ   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    rd_en = (state_q == StRead) && (occ < 3'd2);

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d = StRead;
          shift_d = Shift;
          addr_d  = '0;
        end
      end
      StRead: begin
        if (rd_en) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rd_en) begin
      inflight_d = 1'b1;
      rd_idx_d   = addr_q;
    end
    if (push) begin
      fifo_data_d[wr_ptr_q] = elem;
      fifo_idx_d[wr_ptr_q]  = rd_idx_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    busy_d  = (state_d != StIdle);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      addr_q     <= '0;
      rd_idx_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rd_idx_q    <= rd_idx_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_idx_q  <= fifo_idx_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Acc_Rd_en   = rd_en;
  assign Acc_Rd_Addr = addr_q;
  assign Out_Valid   = (count_q != 2'd0);
  assign Out_Data    = fifo_data_q[rd_ptr_q];
  assign Out_Index   = fifo_idx_q[rd_ptr_q];

endmodule

// File: tb/tb_acc_readout.sv
// Randomized bench for acc_readout with a behavioural scoreboard and a few literal anchors.
module tb_acc_readout;
  localparam int PW = 45;
  localparam int OW = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 Start;
  logic [5:0]           Shift;
  logic                 Busy, Done, Acc_Rd_en, Out_Valid, Out_Ready;
  logic [AW-1:0]        Acc_Rd_Addr, Out_Index;
  logic signed [PW-1:0] Acc_Rd_Data;
  logic signed [OW-1:0] Out_Data;

  acc_readout #(.PARTIAL_SUM_WIDTH(PW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Shift(Shift), .Busy(Busy), .Done(Done),
    .Acc_Rd_en(Acc_Rd_en), .Acc_Rd_Addr(Acc_Rd_Addr), .Acc_Rd_Data(Acc_Rd_Data),
    .Out_Data(Out_Data), .Out_Index(Out_Index), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
  );

  always #5 clk = ~clk;

  // Accumulator memory: one-cycle read latency, garbage when not reading
  logic signed [PW-1:0] mem [D];
  always @(posedge clk) begin
    if (Acc_Rd_en) Acc_Rd_Data <= mem[Acc_Rd_Addr];
    else Acc_Rd_Data <= PW'({$urandom, $urandom});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference requantizer written straight from the arithmetic rules
  function automatic int model(input longint x, input int s);
    longint v;
    if (s == 0) v = x;
    else if (s >= PW) v = (x < 0) ? -1 : 0;
    else v = (x + (longint'(1) <<< (s - 1))) >>> s;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef ACC_READOUT_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  // Scoreboard state
  int  exp_data[$];
  int  exp_idx[$];
  int  seen_q[$];
  bit  pass_active = 1'b0;
  bit  done_exp = 1'b0;
  bit  was_reset = 1'b0;
  bit  prev_stall = 1'b0;
  int  prev_data = 0;
  int  prev_idx = 0;
  int  xfers = 0;
  int  issued = 0;

  // Compare process: checks every cycle against the scoreboard, then advances the model
  always @(negedge clk) begin
    bit xfer;
    bit active_now;
    xfer = Out_Valid && Out_Ready;
    active_now = pass_active;
    if (was_reset) begin
      chk("rst_valid", Out_Valid, 0);
      chk("rst_data", Out_Data, 0);
      chk("rst_index", Out_Index, 0);
      chk("rst_rd_en", Acc_Rd_en, 0);
      chk("rst_rd_addr", Acc_Rd_Addr, 0);
    end
    chk("done", Done, done_exp);
    chk("busy", Busy, active_now);
    if (prev_stall) begin
      chk("stall_valid", Out_Valid, 1);
      chk("stall_data", Out_Data, prev_data);
      chk("stall_index", Out_Index, prev_idx);
    end
    if (xfer) begin
      if (exp_data.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        chk("data", Out_Data, exp_data[0]);
        chk("index", Out_Index, exp_idx[0]);
      end
    end
    if (Acc_Rd_en) begin
      chk("rd_credit", ((issued - xfers - int'(xfer)) < 2), 1);
      chk("rd_addr", Acc_Rd_Addr, issued);
      chk("rd_in_pass", (active_now && issued < D), 1);
    end

    prev_stall = Out_Valid && !Out_Ready;
    prev_data  = int'(Out_Data);
    prev_idx   = int'(Out_Index);
    if (!rst_n) begin
      exp_data.delete();
      exp_idx.delete();
      pass_active = 1'b0;
      done_exp    = 1'b0;
      was_reset   = 1'b1;
      prev_stall  = 1'b0;
      xfers       = 0;
      issued      = 0;
    end else begin
      was_reset = 1'b0;
      done_exp  = 1'b0;
      if (xfer) begin
        seen_q.push_back(int'(Out_Data));
        if (exp_data.size() != 0) begin
          void'(exp_data.pop_front());
          void'(exp_idx.pop_front());
        end
        xfers++;
        if (xfers == D) begin
          done_exp    = 1'b1;
          pass_active = 1'b0;
        end
      end
      if (Acc_Rd_en) issued++;
      if (Start && !active_now) begin
        pass_active = 1'b1;
        xfers  = 0;
        issued = 0;
        for (int i = 0; i < D; i++) begin
          exp_data.push_back(model(longint'(mem[i]), int'(Shift)));
          exp_idx.push_back(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pass; mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready, 3: extra Starts
  task automatic run_pass(input int s, input int mode);
    bit got_done;
    Start = 1'b1;
    Shift = 6'(s);
    tick();
    Start = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      case (mode)
        0: Out_Ready = 1'b1;
        1: Out_Ready = ((k % 4) == 0) || ((k % 4) == 3);
        2: Out_Ready = 1'($urandom_range(0, 1));
        default: begin
          Out_Ready = 1'b1;
          Start = (k % 3) == 1;
          Shift = 6'($urandom_range(0, 63));
        end
      endcase
      tick();
      if (Done) got_done = 1'b1;
    end
    Start = 1'b0;
    Out_Ready = 1'b1;
    chk("pass_done_seen", got_done, 1);
    tick();
  endtask

  int lit0 [8];
  int first_valid, done_at;

  initial begin
    rst_n = 1'b0;
    Start = 1'b0;
    Shift = '0;
    Out_Ready = 1'b1;
    for (int i = 0; i < D; i++) mem[i] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed: saturation at Shift 0 with timing anchors
    mem[0] = 5; mem[1] = -3; mem[2] = 127; mem[3] = 128;
    mem[4] = -128; mem[5] = -129; mem[6] = 0; mem[7] = 1000;
`ifdef ACC_READOUT_RELU_EN
    lit0 = '{5, 0, 127, 127, 0, 0, 0, 127};
`else
    lit0 = '{5, -3, 127, 127, -128, -128, 0, 127};
`endif
    seen_q.delete();
    first_valid = -1;
    done_at = -1;
    Start = 1'b1;
    Shift = 6'd0;
    tick();
    Start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (Out_Valid && first_valid < 0) first_valid = k;
      if (Done && done_at < 0) done_at = k;
    end
    chk("first_valid_cycle", first_valid, 2);
    chk("done_cycle", done_at, 10);
    chk("lit0_count", seen_q.size(), 8);
    if (seen_q.size() == 8)
      for (int i = 0; i < 8; i++) chk("lit0_value", seen_q[i], lit0[i]);

    // Directed: rounding with Shift 4
    mem[0] = 40; mem[1] = -40; mem[2] = (45'sd1 <<< 44) - 45'sd1;
    seen_q.delete();
    run_pass(4, 0);
    chk("lit1_count", seen_q.size(), 8);
    if (seen_q.size() >= 3) begin
      chk("lit1_pos", seen_q[0], 3);
`ifdef ACC_READOUT_RELU_EN
      chk("lit1_neg", seen_q[1], 0);
`else
      chk("lit1_neg", seen_q[1], -2);
`endif
      chk("lit1_big", seen_q[2], 127);
    end

    // Directed: shift beyond entry width
    mem[0] = -5; mem[1] = 5;
    seen_q.delete();
    run_pass(50, 0);
    if (seen_q.size() >= 2) begin
`ifdef ACC_READOUT_RELU_EN
      chk("lit2_neg", seen_q[0], 0);
`else
      chk("lit2_neg", seen_q[0], -1);
`endif
      chk("lit2_pos", seen_q[1], 0);
    end else begin
      chk("lit2_count", seen_q.size(), 8);
    end

    // Directed: ready 1,0,0,1 back-pressure
    for (int i = 0; i < D; i++) mem[i] = PW'(i * 37 - 100);
    seen_q.delete();
    run_pass(1, 1);
    chk("stall_pass_count", seen_q.size(), 8);

    // Directed: reset mid-pass, then immediate restart
    Start = 1'b1;
    Shift = 6'd0;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    seen_q.delete();
    rst_n = 1'b1;
    run_pass(2, 0);
    chk("post_rst_count", seen_q.size(), 8);

    // Directed: Start pulses while busy are ignored
    mem[1] = -3;
    seen_q.delete();
    run_pass(0, 3);
    repeat (4) tick();
    chk("ignored_start_count", seen_q.size(), 8);
    if (seen_q.size() >= 2) begin
`ifdef ACC_READOUT_RELU_EN
      chk("relu_neg3", seen_q[1], 0);
`else
      chk("relu_neg3", seen_q[1], -3);
`endif
    end

    // Randomized passes
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < D; i++) begin
        case ($urandom_range(0, 2))
          0: mem[i] = PW'({$urandom, $urandom});
          1: mem[i] = PW'(int'($urandom_range(0, 4000)) - 2000);
          default: mem[i] = $urandom_range(0, 1) ? ((45'sd1 <<< 44) - 45'sd1)
                                                 : -(45'sd1 <<< 44);
        endcase
      end
      repeat ($urandom_range(0, 3)) tick();
      run_pass($urandom_range(0, 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12)),
               int'($urandom_range(0, 2)));
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
